// File: rtl/qam_stream_demapper_if.sv
// Symbol-in / packed-word-out stream bundle for the QAM demapper.
// The slave side is the demapper; the master side feeds symbols and drains words.
interface qam_stream_demapper_if #(
  parameter int unsigned IN_W  = 16,
  parameter int unsigned OUT_W = 8
) ();
  localparam int unsigned NB_W = $clog2(OUT_W + 1);

  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_i;
  logic [IN_W-1:0]  in_q;
  logic [1:0]       in_mode;
  logic             in_last;

  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic [NB_W-1:0]  out_nbits;
  logic             out_last;

  modport master (
    output in_valid, in_i, in_q, in_mode, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_nbits, out_last
  );

  modport slave (
    input  in_valid, in_i, in_q, in_mode, in_last, out_ready,
    output in_ready, out_valid, out_data, out_nbits, out_last
  );
endinterface

// File: rtl/qam_stream_demapper.sv
// Hard-decision BPSK/QPSK/16-QAM demapper: slice, register, pack bits LSB-first
// into OUT_W-bit words, with a one-word hand-off register ahead of the output.
module qam_stream_demapper #(
  parameter int unsigned IN_W     = 16,
  parameter int unsigned OUT_W    = 8,
  parameter int unsigned LVL_BASE = 10,
  parameter int unsigned LVL_STEP = 10
) (
  input  logic                    clk,
  input  logic                    rst_n,
  qam_stream_demapper_if.slave    bus,
  input  logic                    clr_err,
  output logic                    err_mode
);
  localparam int unsigned FW = $clog2(OUT_W + 1);
  localparam int unsigned SW = FW + 1;
  localparam logic [IN_W-1:0] T1 = IN_W'(LVL_BASE + LVL_STEP / 2);
  localparam logic [IN_W-1:0] T2 = IN_W'(LVL_BASE + LVL_STEP / 2 + LVL_STEP);
  localparam logic [IN_W-1:0] T3 = IN_W'(LVL_BASE + LVL_STEP / 2 + 2 * LVL_STEP);

  function automatic logic [1:0] slice_lvl(input logic [IN_W-1:0] x);
    if (x < T1)      return 2'd0;
    else if (x < T2) return 2'd1;
    else if (x < T3) return 2'd2;
    else             return 2'd3;
  endfunction

  logic             s1_valid_q, s1_valid_d;
  logic [3:0]       s1_bits_q, s1_bits_d;
  logic [2:0]       s1_w_q, s1_w_d;
  logic             s1_last_q, s1_last_d;
  logic [OUT_W-1:0] acc_q, acc_d;
  logic [FW-1:0]    fill_q, fill_d;
  logic             em_valid_q, em_valid_d;
  logic [OUT_W-1:0] em_data_q, em_data_d;
  logic [FW-1:0]    em_nbits_q, em_nbits_d;
  logic             em_last_q, em_last_d;
  logic             ov_q, ov_d;
  logic [OUT_W-1:0] od_q, od_d;
  logic [FW-1:0]    on_q, on_d;
  logic             ol_q, ol_d;
  logic             err_q, err_d;

  logic [3:0]       sym_bits;
  logic [2:0]       sym_w;
  logic [1:0]       k_i, k_q;
  logic             slot_free, em_free, step, split, consume, accept;
  logic [SW-1:0]    sum;
  logic [FW-1:0]    new_fill;
  logic [OUT_W-1:0] new_acc;

  // Slicer and bit mapper on the incoming symbol
  always_comb begin
    sym_bits = 4'd0;
    sym_w    = 3'd0;
    k_i      = slice_lvl(bus.in_i);
    k_q      = slice_lvl(bus.in_q);
    case (bus.in_mode)
      2'd0: begin
        sym_bits = {3'b000, bus.in_i >= T2};
        sym_w    = 3'd1;
      end
      2'd1: begin
        sym_bits = {2'b00, bus.in_q < T2, bus.in_i >= T2};
        sym_w    = 3'd2;
      end
      2'd2: begin
        sym_bits = {~k_q, k_i ^ 2'b01};
        sym_w    = 3'd4;
      end
      default: begin
        sym_bits = 4'd0;
        sym_w    = 3'd0;
      end
    endcase
  end

  // Packer, hand-off register and output register next state
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_bits_d  = s1_bits_q;
    s1_w_d     = s1_w_q;
    s1_last_d  = s1_last_q;
    acc_d      = acc_q;
    fill_d     = fill_q;
    em_data_d  = em_data_q;
    em_nbits_d = em_nbits_q;
    em_last_d  = em_last_q;
    ov_d       = ov_q;
    od_d       = od_q;
    on_d       = on_q;
    ol_d       = ol_q;

    slot_free  = !ov_q || bus.out_ready;
    em_free    = !em_valid_q || slot_free;
    em_valid_d = em_free ? 1'b0 : em_valid_q;
    sum        = SW'(fill_q) + SW'(s1_w_q);
    step       = s1_valid_q && em_free;
    split      = step && (sum > SW'(OUT_W));
    consume    = step && !split;
    new_fill   = sum[FW-1:0];
    new_acc    = acc_q | (OUT_W'(s1_bits_q) << fill_q);
    bus.in_ready = !s1_valid_q || consume;
    accept     = bus.in_valid && bus.in_ready;
    err_d      = (err_q && !clr_err) || (accept && bus.in_mode == 2'd3);

    if (slot_free) begin
      ov_d = em_valid_q;
      if (em_valid_q) begin
        od_d = em_data_q;
        on_d = em_nbits_q;
        ol_d = em_last_q;
      end
    end

    if (split) begin
      em_valid_d = 1'b1;
      em_data_d  = acc_q;
      em_nbits_d = fill_q;
      em_last_d  = 1'b0;
      acc_d      = '0;
      fill_d     = '0;
    end else if (consume) begin
      if (new_fill == FW'(OUT_W) || (s1_last_q && new_fill != '0)) begin
        em_valid_d = 1'b1;
        em_data_d  = new_acc;
        em_nbits_d = new_fill;
        em_last_d  = s1_last_q;
        acc_d      = '0;
        fill_d     = '0;
      end else begin
        acc_d  = new_acc;
        fill_d = new_fill;
      end
    end

    if (accept) begin
      s1_valid_d = 1'b1;
      s1_bits_d  = sym_bits;
      s1_w_d     = sym_w;
      s1_last_d  = bus.in_last;
    end else if (consume) begin
      s1_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_bits_q  <= '0;
      s1_w_q     <= '0;
      s1_last_q  <= 1'b0;
      acc_q      <= '0;
      fill_q     <= '0;
      em_valid_q <= 1'b0;
      em_data_q  <= '0;
      em_nbits_q <= '0;
      em_last_q  <= 1'b0;
      ov_q       <= 1'b0;
      od_q       <= '0;
      on_q       <= '0;
      ol_q       <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_bits_q  <= s1_bits_d;
      s1_w_q     <= s1_w_d;
      s1_last_q  <= s1_last_d;
      acc_q      <= acc_d;
      fill_q     <= fill_d;
      em_valid_q <= em_valid_d;
      em_data_q  <= em_data_d;
      em_nbits_q <= em_nbits_d;
      em_last_q  <= em_last_d;
      ov_q       <= ov_d;
      od_q       <= od_d;
      on_q       <= on_d;
      ol_q       <= ol_d;
      err_q      <= err_d;
    end
  end

  assign bus.out_valid = ov_q;
  assign bus.out_data  = od_q;
  assign bus.out_nbits = on_q;
  assign bus.out_last  = ol_q;
  assign err_mode      = err_q;
endmodule

// File: tb/tb_qam_stream_demapper.sv
// Directed bench for qam_stream_demapper: bit-list reference model plus
// literal checks on the words each scenario must produce.
module tb_qam_stream_demapper;
  localparam int unsigned IN_W  = 16;
  localparam int unsigned OUT_W = 8;
  localparam int unsigned NB_W  = $clog2(OUT_W + 1);
  localparam int LB = 10;
  localparam int LS = 10;
  localparam int T2 = LB + LS / 2 + LS;

  typedef struct {
    logic [OUT_W-1:0] data;
    logic [NB_W-1:0]  nb;
    logic             last;
  } word_t;

  logic clk = 1'b0;
  logic rst_n;
  logic clr_err;
  logic err_mode;

  qam_stream_demapper_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();

  qam_stream_demapper #(.IN_W(IN_W), .OUT_W(OUT_W), .LVL_BASE(LB), .LVL_STEP(LS)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus.slave),
    .clr_err  (clr_err),
    .err_mode (err_mode)
  );

  always #5 clk = ~clk;

  int    vectors = 0;
  int    miscompares = 0;
  int    stall_cnt = 0;
  word_t exp_q[$];
  word_t got[$];
  logic [OUT_W-1:0] pend = '0;
  int    pend_n = 0;
  logic  exp_err = 1'b0;
  logic [1:0] imap [4] = '{2'b01, 2'b00, 2'b11, 2'b10};
  logic [1:0] qmap [4] = '{2'b11, 2'b10, 2'b01, 2'b00};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Number of thresholds the amplitude meets or exceeds
  function automatic int lvl(input int x);
    int k = 0;
    for (int j = 0; j < 3; j++) if (x >= LB + LS / 2 + j * LS) k++;
    return k;
  endfunction

  function automatic void push_word(input logic last);
    word_t wd;
    wd.data = pend;
    wd.nb   = NB_W'(pend_n);
    wd.last = last;
    exp_q.push_back(wd);
    pend   = '0;
    pend_n = 0;
  endfunction

  function automatic void model_accept(input int i, input int q, input int m, input logic last);
    int w;
    logic [3:0] b;
    case (m)
      0:       begin w = 1; b = {3'b000, i >= T2}; end
      1:       begin w = 2; b = {2'b00, q < T2, i >= T2}; end
      2:       begin w = 4; b = {qmap[lvl(q)], imap[lvl(i)]}; end
      default: begin w = 0; b = 4'd0; end
    endcase
    if (pend_n + w > OUT_W) push_word(1'b0);
    for (int k = 0; k < w; k++) pend[pend_n + k] = b[k];
    pend_n += w;
    if (pend_n == OUT_W || (last && pend_n > 0)) push_word(last);
  endfunction

  // Per-cycle compare against the model, away from the active edge
  always @(negedge clk) begin
    if (rst_n) begin
      chk("err_mode", err_mode, exp_err);
      exp_err = (exp_err && !clr_err) || (bus.in_valid && bus.in_ready && bus.in_mode == 2'd3);
      if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          chk("spurious_out_valid", bus.out_valid, 1'b0);
        end else begin
          chk("out_data", bus.out_data, exp_q[0].data);
          chk("out_nbits", bus.out_nbits, exp_q[0].nb);
          chk("out_last", bus.out_last, exp_q[0].last);
          if (bus.out_ready) begin
            word_t wd;
            wd.data = bus.out_data;
            wd.nb   = bus.out_nbits;
            wd.last = bus.out_last;
            got.push_back(wd);
            void'(exp_q.pop_front());
          end
        end
      end
      if (bus.in_valid && !bus.in_ready) stall_cnt++;
      if (bus.in_valid && bus.in_ready)
        model_accept(int'(bus.in_i), int'(bus.in_q), int'(bus.in_mode), bus.in_last);
    end
  end

  // Called right after a rising edge; returns right after the accepting edge
  task automatic send(input int i, input int q, input int m, input logic last);
    bit done = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_i     = IN_W'(i);
    bus.in_q     = IN_W'(q);
    bus.in_mode  = 2'(m);
    bus.in_last  = last;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk);
      if (bus.in_ready) done = 1'b1;
      @(posedge clk); #1;
    end
    if (!done) chk("send_timeout", 32'(done), 32'd1);
    bus.in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic chk_word(input string nm, input int idx, input logic [OUT_W-1:0] d,
                          input int nb, input logic l);
    chk({nm, "_present"}, 32'(got.size() > idx), 32'd1);
    if (got.size() > idx) begin
      chk({nm, "_data"}, got[idx].data, d);
      chk({nm, "_nbits"}, got[idx].nb, 32'(nb));
      chk({nm, "_last"}, got[idx].last, l);
    end
  endtask

  initial begin
    int base;
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int base;
    rst_n = 1'b0; clr_err = 1'b0;
    bus.in_valid = 1'b0; bus.in_i = '0; bus.in_q = '0; bus.in_mode = '0; bus.in_last = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_out_data", bus.out_data, 8'h00);
    chk("rst_out_nbits", bus.out_nbits, 0);
    chk("rst_out_last", bus.out_last, 1'b0);
    chk("rst_err_mode", err_mode, 1'b0);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", bus.in_ready, 1'b1);
    @(posedge clk); #1;

    // 16-QAM word and two-edge latency
    base = got.size();
    send(16'h14, 16'h28, 2, 1'b0);
    send(16'h0A, 16'h1E, 2, 1'b0);
    chk("lat_edge_n", bus.out_valid, 1'b0);
    @(posedge clk); #1;
    chk("lat_edge_n1", bus.out_valid, 1'b0);
    @(posedge clk); #1;
    chk("lat_edge_n2", bus.out_valid, 1'b1);
    idle(4);
    chk_word("qam16", base, 8'h50, 8, 1'b0);

    // Slicer boundaries
    base = got.size();
    send(16'h0E, 16'h0000, 2, 1'b0);
    send(16'h0F, 16'h0000, 2, 1'b0);
    send(16'hFFFF, 16'h0019, 2, 1'b1);
    idle(5);
    chk_word("bound_w0", base, 8'hCD, 8, 1'b0);
    chk_word("bound_w1", base + 1, 8'h06, 4, 1'b1);

    // QPSK
    base = got.size();
    send(40, 10, 1, 1'b0);
    send(10, 40, 1, 1'b0);
    send(30, 20, 1, 1'b0);
    send(20, 30, 1, 1'b1);
    idle(5);
    chk_word("qpsk", base, 8'h33, 8, 1'b1);

    // Mixed widths: one split bubble
    base = got.size();
    stall_cnt = 0;
    send(40, 10, 1, 1'b0);
    send(10, 30, 2, 1'b0);
    send(40, 10, 2, 1'b1);
    send(40, 0, 0, 1'b1);
    idle(5);
    chk("mix_bubble", 32'(stall_cnt), 32'd1);
    chk_word("mix_w0", base, 8'h17, 6, 1'b0);
    chk_word("mix_w1", base + 1, 8'h0E, 4, 1'b1);
    chk_word("mix_w2", base + 2, 8'h01, 1, 1'b1);

    // Backpressure
    base = got.size();
    stall_cnt = 0;
    fork
      begin
        send(10, 10, 2, 1'b0);
        send(20, 20, 2, 1'b0);
        send(30, 30, 2, 1'b0);
        send(40, 40, 2, 1'b0);
        send(10, 40, 2, 1'b0);
        send(40, 10, 2, 1'b1);
      end
      begin
        bus.out_ready = 1'b0;
        repeat (8) @(posedge clk);
        #1 bus.out_ready = 1'b1;
      end
    join
    idle(6);
    chk("bp_in_ready_fell", 32'(stall_cnt > 0), 32'd1);
    chk_word("bp_w0", base, 8'h8D, 8, 1'b0);
    chk_word("bp_w1", base + 1, 8'h27, 8, 1'b0);
    chk_word("bp_w2", base + 2, 8'hE1, 8, 1'b1);

    // Reserved mode: closes frame, sets sticky flag, clear, set-wins
    base = got.size();
    send(40, 10, 1, 1'b0);
    send(0, 0, 3, 1'b1);
    idle(4);
    chk_word("m3_close", base, 8'h03, 2, 1'b1);
    chk("m3_err_set", err_mode, 1'b1);
    clr_err = 1'b1;
    @(posedge clk); #1;
    clr_err = 1'b0;
    chk("m3_err_clr", err_mode, 1'b0);
    clr_err = 1'b1;
    send(0, 0, 3, 1'b0);
    clr_err = 1'b0;
    chk("m3_set_wins", err_mode, 1'b1);
    idle(2);

    // Reset mid-frame
    send(40, 10, 1, 1'b0);
    rst_n = 1'b0;
    exp_q.delete();
    pend = '0; pend_n = 0; exp_err = 1'b0;
    #1;
    chk("mid_rst_out_valid", bus.out_valid, 1'b0);
    chk("mid_rst_out_data", bus.out_data, 8'h00);
    chk("mid_rst_out_nbits", bus.out_nbits, 0);
    chk("mid_rst_out_last", bus.out_last, 1'b0);
    chk("mid_rst_err_mode", err_mode, 1'b0);
    idle(2);
    rst_n = 1'b1;
    @(posedge clk); #1;
    base = got.size();
    send(40, 10, 1, 1'b0);
    send(10, 40, 1, 1'b0);
    send(30, 20, 1, 1'b0);
    send(20, 30, 1, 1'b1);
    idle(5);
    chk_word("post_rst", base, 8'h33, 8, 1'b1);
    chk("post_rst_word_count", 32'(got.size() - base), 32'd1);

    idle(5);
    chk("words_outstanding", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
